// File: rtl/dm_if.sv
// MEM-stage data-memory request/response bundle between the pipeline and the responder.
interface dm_if;
  logic        mem_DM_read;
  logic        mem_DM_write;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_sw_o;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        dm_misalign;

  modport master (
    output mem_DM_read, mem_DM_write, mem_alu_result, mem_sw_o,
    input  dm_rdata, dm_done, dm_stall, dm_misalign
  );

  modport slave (
    input  mem_DM_read, mem_DM_write, mem_alu_result, mem_sw_o,
    output dm_rdata, dm_done, dm_stall, dm_misalign
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word array with configurable access latency, combinational
// stall while an access is pending, registered load data and completion/misalign pulses.
module dm_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  dm_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [31:0]       mem [DEPTH];
  logic              req, mis, go, stall;
  logic [ADDR_W-1:0] idx;

  assign req = bus.mem_DM_read | bus.mem_DM_write;
  assign mis = req & (bus.mem_alu_result[1:0] != 2'b00);
  assign idx = bus.mem_alu_result[ADDR_W+1:2];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    go       = 1'b0;
    case (state)
      IDLE: begin
        if (req && !mis) begin
          if (WAIT_CYCLES == 0) begin
            go = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = WAIT;
            cnt_nx   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        // A dropped (or corrupted) request is a flush: abandon without touching memory.
        if (!req || mis) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else if (cnt != 4'd0) begin
          stall  = 1'b1;
          cnt_nx = cnt - 4'd1;
        end else begin
          go       = 1'b1;
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  assign bus.dm_stall = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      bus.dm_rdata    <= 32'd0;
      bus.dm_done     <= 1'b0;
      bus.dm_misalign <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      bus.dm_done     <= go;
      bus.dm_misalign <= mis;
      if (go && !bus.mem_DM_write) begin
        bus.dm_rdata <= mem[idx];
      end
    end
  end

  // Array is never cleared; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (go && bus.mem_DM_write && !rst) begin
      mem[idx] <= bus.mem_sw_o;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (WAIT_CYCLES 2, 0, 3) share one stimulus bus,
// gated per instance; table-driven accesses plus hand sequences, scoreboard-checked.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  int          sel;

  always #5 clk = ~clk;

  dm_if b0 ();
  dm_if b1 ();
  dm_if b2 ();

  assign b0.mem_DM_read    = rd & (sel == 0);
  assign b0.mem_DM_write   = wr & (sel == 0);
  assign b0.mem_alu_result = addr;
  assign b0.mem_sw_o       = wdata;
  assign b1.mem_DM_read    = rd & (sel == 1);
  assign b1.mem_DM_write   = wr & (sel == 1);
  assign b1.mem_alu_result = addr;
  assign b1.mem_sw_o       = wdata;
  assign b2.mem_DM_read    = rd & (sel == 2);
  assign b2.mem_DM_write   = wr & (sel == 2);
  assign b2.mem_alu_result = addr;
  assign b2.mem_sw_o       = wdata;

  dm_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dm_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  dm_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u2 (.clk(clk), .rst(rst), .bus(b2));

  logic [31:0] o_rdata [3];
  logic        o_done  [3];
  logic        o_stall [3];
  logic        o_mis   [3];

  assign o_rdata[0] = b0.dm_rdata;
  assign o_rdata[1] = b1.dm_rdata;
  assign o_rdata[2] = b2.dm_rdata;
  assign o_done[0]  = b0.dm_done;
  assign o_done[1]  = b1.dm_done;
  assign o_done[2]  = b2.dm_done;
  assign o_stall[0] = b0.dm_stall;
  assign o_stall[1] = b1.dm_stall;
  assign o_stall[2] = b2.dm_stall;
  assign o_mis[0]   = b0.dm_misalign;
  assign o_mis[1]   = b1.dm_misalign;
  assign o_mis[2]   = b2.dm_misalign;

  typedef struct {
    int          k;
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    int          hold;
    int          gap;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          done;
    bit          mis;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl_mem [int];
  logic [31:0] exp_rd [3];
  int          wc [3] = '{2, 0, 3};
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", name, sel, $time, act, expv);
  endtask

  // One request cycle: c is the index of this cycle within the held request.
  task automatic tick(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int c);
    bit   req;
    bit   m;
    bit   comp;
    int   key;
    exp_t e;
    req  = r | w;
    m    = req && (a[1:0] != 2'b00);
    comp = req && !m && (c == wc[sel]);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    chk("stall", 32'(o_stall[sel]), 32'(req && !m && (c < wc[sel])));
    @(posedge clk);
    if (comp) begin
      key = sel * 4096 + int'(a[11:2]);
      if (w) mdl_mem[key] = d;
      else exp_rd[sel] = mdl_mem.exists(key) ? mdl_mem[key] : 32'd0;
    end
    e.done  = comp;
    e.mis   = m;
    e.rdata = exp_rd[sel];
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("done", 32'(o_done[sel]), 32'(e.done));
    chk("misalign", 32'(o_mis[sel]), 32'(e.mis));
    chk("rdata", o_rdata[sel], e.rdata);
  endtask

  initial begin
    vec_t tbl [$];
    tbl.push_back('{0, 1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 3, 0, 32'h0});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h10,   32'h0,        3, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h20,   32'h11,       1, 0, 32'h0});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h20,   32'h0,        1, 0, 32'h11});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h13,   32'h0,        1, 1, 32'h11});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h13,   32'h0,        2, 1, 32'h11});
    tbl.push_back('{1, 1'b1, 1'b1, 32'h30,   32'h55,       1, 0, 32'h11});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h30,   32'h0,        1, 0, 32'h55});
    tbl.push_back('{0, 1'b1, 1'b1, 32'h30,   32'hAB,       3, 0, 32'hDEADBEEF});
    tbl.push_back('{2, 1'b0, 1'b1, 32'h40,   32'h99,       4, 0, 32'h0});
    tbl.push_back('{2, 1'b0, 1'b1, 32'h40,   32'h77,       2, 1, 32'h0});
    tbl.push_back('{2, 1'b1, 1'b0, 32'h40,   32'h0,        4, 0, 32'h99});
    tbl.push_back('{0, 1'b0, 1'b1, 32'h1000, 32'hA5,       3, 0, 32'hDEADBEEF});
    tbl.push_back('{0, 1'b1, 1'b0, 32'h0,    32'h0,        3, 0, 32'hA5});
    tbl.push_back('{1, 1'b0, 1'b1, 32'h1004, 32'h5A,       1, 0, 32'h55});
    tbl.push_back('{1, 1'b1, 1'b0, 32'h4,    32'h0,        1, 0, 32'h5A});

    rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; sel = 0;
    exp_rd = '{32'd0, 32'd0, 32'd0};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("reset_rdata", o_rdata[k], 32'd0);
      chk("reset_done", 32'(o_done[k]), 32'd0);
      chk("reset_misalign", 32'(o_mis[k]), 32'd0);
    end
    rst = 1'b0;
    sel = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'd0, 32'd0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      sel = tbl[i].k;
      for (int c = 0; c < tbl[i].hold; c++) tick(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, c);
      for (int g = 0; g < tbl[i].gap; g++) tick(1'b0, 1'b0, 32'd0, 32'd0, 0);
      chk("final_rdata", o_rdata[sel], tbl[i].exp_rdata);
    end

    // Reset arriving while a write to 0x40 is still waiting on the 3-cycle instance.
    sel = 2;
    tick(1'b0, 1'b1, 32'h40, 32'h77, 0);
    tick(1'b0, 1'b1, 32'h40, 32'h77, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rdata", o_rdata[2], 32'd0);
    chk("midrst_done", 32'(o_done[2]), 32'd0);
    chk("midrst_misalign", 32'(o_mis[2]), 32'd0);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '{32'd0, 32'd0, 32'd0};
    tick(1'b0, 1'b0, 32'd0, 32'd0, 0);
    for (int c = 0; c < 4; c++) tick(1'b1, 1'b0, 32'h40, 32'd0, c);
    chk("after_rst_0x40", o_rdata[2], 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
